// File: rtl/mysystem_sysid_checker.sv
// Reads the sysid ID/timestamp words over Avalon-MM and publishes a registered verdict,
// a sticky error flag and a saturating mismatch count; supports auto, on-demand and periodic checks.
module mysystem_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5745_98FA,
   parameter bit          AUTO_START         = 1'b1,
   parameter int unsigned CHECK_PERIOD       = 0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        match,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic        error_sticky,
   output logic [7:0]  mismatch_count
);

   localparam int unsigned CNT_W = 24;
   localparam bit PERIODIC = (CHECK_PERIOD != 0);
   localparam logic [CNT_W-1:0] PERIOD_M1 =
      (CHECK_PERIOD > 0) ? CNT_W'(CHECK_PERIOD - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_ID   = 3'd1,
      S_RD_TS   = 3'd2,
      S_COMPARE = 3'd3,
      S_WAIT    = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic              r_auto_pend;
   logic [CNT_W-1:0]  r_wait_cnt;
   logic              r_avm_read;
   logic              r_avm_address;
   logic              r_busy;
   logic              r_done;
   logic              r_match;
   logic [31:0]       r_id_value;
   logic [31:0]       r_ts_value;
   logic              r_error_sticky;
   logic [7:0]        r_mismatch_count;

   logic              w_read;
   logic              w_addr;
   logic              w_busy;
   logic              w_pass;

   // State register
   always_ff @(posedge clock) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   // Next-state logic; start is only honoured in IDLE and WAIT
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE:    if (r_auto_pend || start) w_next_state = S_RD_ID;
         S_RD_ID:   w_next_state = S_RD_TS;
         S_RD_TS:   w_next_state = S_COMPARE;
         S_COMPARE: w_next_state = PERIODIC ? S_WAIT : S_IDLE;
         S_WAIT:    if (start || (r_wait_cnt == '0)) w_next_state = S_RD_ID;
         default:   w_next_state = S_IDLE;
      endcase
   end

   // Output decode from the next state so the bus strobes are registered yet aligned to the state
   always_comb begin
      w_read = 1'b0;
      w_addr = 1'b0;
      w_busy = 1'b0;
      w_pass = (r_id_value == EXPECTED_ID) && (r_ts_value == EXPECTED_TIMESTAMP);
      if ((w_next_state == S_RD_ID) || (w_next_state == S_RD_TS)) w_read = 1'b1;
      if (w_next_state == S_RD_TS) w_addr = 1'b1;
      if ((w_next_state == S_RD_ID) || (w_next_state == S_RD_TS) ||
          (w_next_state == S_COMPARE)) w_busy = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_auto_pend      <= AUTO_START;
         r_wait_cnt       <= '0;
         r_avm_read       <= 1'b0;
         r_avm_address    <= 1'b0;
         r_busy           <= 1'b0;
         r_done           <= 1'b0;
         r_match          <= 1'b0;
         r_id_value       <= '0;
         r_ts_value       <= '0;
         r_error_sticky   <= 1'b0;
         r_mismatch_count <= '0;
      end else begin
         r_auto_pend   <= 1'b0;
         r_avm_read    <= w_read;
         r_avm_address <= w_addr;
         r_busy        <= w_busy;
         r_done        <= (r_state == S_COMPARE);
         if (r_state == S_RD_ID) r_id_value <= avm_readdata;
         if (r_state == S_RD_TS) r_ts_value <= avm_readdata;
         if (r_state == S_COMPARE) begin
            r_match <= w_pass;
            if (!w_pass) begin
               r_error_sticky <= 1'b1;
               if (r_mismatch_count != 8'hFF) r_mismatch_count <= r_mismatch_count + 8'd1;
            end
         end
         // Wait counter: loaded leaving COMPARE, counts down while waiting
         if (r_state == S_COMPARE)                        r_wait_cnt <= PERIOD_M1;
         else if ((r_state == S_WAIT) && (r_wait_cnt != '0)) r_wait_cnt <= r_wait_cnt - CNT_W'(1);
      end
   end

   assign avm_read       = r_avm_read;
   assign avm_address    = r_avm_address;
   assign busy           = r_busy;
   assign done           = r_done;
   assign match          = r_match;
   assign id_value       = r_id_value;
   assign ts_value       = r_ts_value;
   assign error_sticky   = r_error_sticky;
   assign mismatch_count = r_mismatch_count;

endmodule

// File: tb/tb_mysystem_sysid_checker.sv
// Scoreboard bench: instance A (auto-start, no period) and instance P (on-demand, period 10).
module tb_mysystem_sysid_checker;

   localparam logic [31:0] GOOD_TS = 32'h5745_98FA;
   localparam logic [31:0] BAD_TS  = 32'h5745_98FB;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic        rst_a_n, start_a, addr_a, read_a, busy_a, done_a, match_a, err_a;
   logic [31:0] id_a, ts_a, rdata_a, idv_a, tsv_a;
   logic [7:0]  cnt_a;
   logic        rst_p_n, start_p, addr_p, read_p, busy_p, done_p, match_p, err_p;
   logic [31:0] id_p, ts_p, rdata_p, idv_p, tsv_p;
   logic [7:0]  cnt_p;

   // Sysid slave models: data combinational from address
   assign rdata_a = addr_a ? ts_a : id_a;
   assign rdata_p = addr_p ? ts_p : id_p;

   mysystem_sysid_checker #(
      .EXPECTED_ID(32'h0), .EXPECTED_TIMESTAMP(GOOD_TS), .AUTO_START(1'b1), .CHECK_PERIOD(0)
   ) dut_a (
      .clock(clk), .reset_n(rst_a_n), .start(start_a),
      .avm_address(addr_a), .avm_read(read_a), .avm_readdata(rdata_a),
      .busy(busy_a), .done(done_a), .match(match_a),
      .id_value(idv_a), .ts_value(tsv_a),
      .error_sticky(err_a), .mismatch_count(cnt_a)
   );

   mysystem_sysid_checker #(
      .EXPECTED_ID(32'h0), .EXPECTED_TIMESTAMP(GOOD_TS), .AUTO_START(1'b0), .CHECK_PERIOD(10)
   ) dut_p (
      .clock(clk), .reset_n(rst_p_n), .start(start_p),
      .avm_address(addr_p), .avm_read(read_p), .avm_readdata(rdata_p),
      .busy(busy_p), .done(done_p), .match(match_p),
      .id_value(idv_p), .ts_value(tsv_p),
      .error_sticky(err_p), .mismatch_count(cnt_p)
   );

   typedef struct packed {
      int unsigned cyc;
      logic        m;
      logic [31:0] id;
      logic [31:0] ts;
      logic        e;
      logic [7:0]  cnt;
   } exp_t;

   exp_t q_a[$];
   exp_t q_p[$];
   exp_t ea, ep;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t mk(input int unsigned c, input logic m, input logic [31:0] id,
                               input logic [31:0] ts, input logic e, input logic [7:0] cnt);
      exp_t x;
      x.cyc = c; x.m = m; x.id = id; x.ts = ts; x.e = e; x.cnt = cnt;
      return x;
   endfunction

   // Monitors: pop and compare on every done pulse
   always @(negedge clk) begin
      if (done_a === 1'b1) begin
         chk("a_done_expected", 32'(q_a.size() != 0), 32'd1);
         if (q_a.size() != 0) begin
            ea = q_a.pop_front();
            chk("a_done_cycle", cyc, ea.cyc);
            chk("a_match", 32'(match_a), 32'(ea.m));
            chk("a_id_value", idv_a, ea.id);
            chk("a_ts_value", tsv_a, ea.ts);
            chk("a_error_sticky", 32'(err_a), 32'(ea.e));
            chk("a_mismatch_count", 32'(cnt_a), 32'(ea.cnt));
            chk("a_busy_at_done", 32'(busy_a), 32'd0);
         end
      end
      if (done_p === 1'b1) begin
         chk("p_done_expected", 32'(q_p.size() != 0), 32'd1);
         if (q_p.size() != 0) begin
            ep = q_p.pop_front();
            chk("p_done_cycle", cyc, ep.cyc);
            chk("p_match", 32'(match_p), 32'(ep.m));
            chk("p_id_value", idv_p, ep.id);
            chk("p_ts_value", tsv_p, ep.ts);
            chk("p_error_sticky", 32'(err_p), 32'(ep.e));
            chk("p_mismatch_count", 32'(cnt_p), 32'(ep.cnt));
         end
      end
   end

   task automatic chk_zero_a(input string tag);
      chk({tag, "_read"},  32'(read_a),  32'd0);
      chk({tag, "_addr"},  32'(addr_a),  32'd0);
      chk({tag, "_busy"},  32'(busy_a),  32'd0);
      chk({tag, "_done"},  32'(done_a),  32'd0);
      chk({tag, "_match"}, 32'(match_a), 32'd0);
      chk({tag, "_idv"},   idv_a,        32'd0);
      chk({tag, "_tsv"},   tsv_a,        32'd0);
      chk({tag, "_err"},   32'(err_a),   32'd0);
      chk({tag, "_cnt"},   32'(cnt_a),   32'd0);
   endtask

   task automatic drain_a();
      for (int n = 0; n < 40 && q_a.size() != 0; n++) @(negedge clk);
      chk("a_queue_drained", 32'(q_a.size()), 32'd0);
   endtask

   task automatic wait_rdid_p(output int unsigned c);
      for (int n = 0; n < 20; n++) begin
         if (read_p && !addr_p) break;
         @(negedge clk);
      end
      c = cyc;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned e0, r, rk, r5;
      logic [7:0]  cnt_exp;
      rst_a_n = 1'b0; rst_p_n = 1'b0; start_a = 1'b0; start_p = 1'b0;
      id_a = 32'h0; ts_a = GOOD_TS; id_p = 32'h0; ts_p = GOOD_TS;
      repeat (3) @(negedge clk);
      chk_zero_a("rst_a");
      chk("rst_p_read", 32'(read_p), 32'd0);
      chk("rst_p_busy", 32'(busy_p), 32'd0);
      chk("rst_p_cnt",  32'(cnt_p),  32'd0);

      // Auto-start pass on A
      rst_a_n = 1'b1; rst_p_n = 1'b1;
      r = cyc + 1;
      q_a.push_back(mk(r + 3, 1'b1, 32'h0, GOOD_TS, 1'b0, 8'd0));
      @(negedge clk);
      chk("auto_rdid_read", 32'(read_a), 32'd1);
      chk("auto_rdid_addr", 32'(addr_a), 32'd0);
      chk("auto_rdid_busy", 32'(busy_a), 32'd1);
      @(negedge clk);
      chk("auto_rdts_read", 32'(read_a), 32'd1);
      chk("auto_rdts_addr", 32'(addr_a), 32'd1);
      @(negedge clk);
      chk("auto_cmp_read", 32'(read_a), 32'd0);
      chk("auto_cmp_addr", 32'(addr_a), 32'd0);
      chk("auto_cmp_busy", 32'(busy_a), 32'd1);
      repeat (4) @(negedge clk);
      chk("auto_idle_read", 32'(read_a), 32'd0);
      chk("auto_idle_busy", 32'(busy_a), 32'd0);
      chk("auto_match_held", 32'(match_a), 32'd1);
      chk("p_idle_no_autostart", 32'(busy_p), 32'd0);
      drain_a();

      // On-demand fail: bad timestamp
      ts_a = BAD_TS; start_a = 1'b1; e0 = cyc + 1;
      q_a.push_back(mk(e0 + 3, 1'b0, 32'h0, BAD_TS, 1'b1, 8'd1));
      @(negedge clk); start_a = 1'b0;
      repeat (8) @(negedge clk);
      chk("fail_match_held", 32'(match_a), 32'd0);
      drain_a();

      // Start while busy (RD_TS and COMPARE) is ignored
      ts_a = GOOD_TS; start_a = 1'b1; e0 = cyc + 1;
      q_a.push_back(mk(e0 + 3, 1'b1, 32'h0, GOOD_TS, 1'b1, 8'd1));
      @(negedge clk); start_a = 1'b0;
      @(negedge clk); start_a = 1'b1;
      @(negedge clk);
      @(negedge clk); start_a = 1'b0;
      repeat (8) @(negedge clk);
      chk("busy_start_not_queued", 32'(busy_a), 32'd0);
      drain_a();

      // Saturation: alternate ID and timestamp mismatches
      cnt_exp = 8'd1;
      for (int i = 0; i < 260; i++) begin
         if (i % 2 == 1) begin id_a = 32'h0000_0001; ts_a = GOOD_TS; end
         else            begin id_a = 32'h0;         ts_a = BAD_TS;  end
         if (cnt_exp != 8'hFF) cnt_exp = cnt_exp + 8'd1;
         start_a = 1'b1; e0 = cyc + 1;
         q_a.push_back(mk(e0 + 3, 1'b0, id_a, ts_a, 1'b1, cnt_exp));
         @(negedge clk); start_a = 1'b0;
         repeat (4) @(negedge clk);
      end
      drain_a();
      chk("sat_count", 32'(cnt_a), 32'd255);
      chk("sat_sticky", 32'(err_a), 32'd1);

      // Mid-check reset during RD_TS; auto-start then runs a fresh check
      id_a = 32'h0; ts_a = GOOD_TS; start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      chk("midrst_rdid_busy", 32'(busy_a), 32'd1);
      @(negedge clk);
      chk("midrst_rdts_addr", 32'(addr_a), 32'd1);
      rst_a_n = 1'b0;
      @(negedge clk);
      chk_zero_a("midrst");
      @(negedge clk);
      chk("midrst_no_done", 32'(done_a), 32'd0);
      rst_a_n = 1'b1; r = cyc + 1;
      q_a.push_back(mk(r + 3, 1'b1, 32'h0, GOOD_TS, 1'b0, 8'd0));
      repeat (6) @(negedge clk);
      drain_a();

      // Periodic on P: RD_ID every 13 cycles
      start_p = 1'b1; e0 = cyc + 1;
      for (int k = 0; k < 5; k++)
         q_p.push_back(mk(e0 + 13 * k + 3, 1'b1, 32'h0, GOOD_TS, 1'b0, 8'd0));
      @(negedge clk); start_p = 1'b0;
      rk = e0;
      for (int k = 0; k < 5; k++) begin
         wait_rdid_p(rk);
         chk("per_rdid_cycle", rk, e0 + 13 * k);
         @(negedge clk);
         chk("per_rdts_addr", 32'(addr_p), 32'd1);
         chk("per_rdts_read", 32'(read_p), 32'd1);
      end
      // Abort WAIT when its counter is 5
      while (cyc < rk + 7) @(negedge clk);
      chk("wait_read_low", 32'(read_p), 32'd0);
      chk("wait_busy_low", 32'(busy_p), 32'd0);
      start_p = 1'b1; r5 = cyc + 1;
      q_p.push_back(mk(r5 + 3, 1'b1, 32'h0, GOOD_TS, 1'b0, 8'd0));
      @(negedge clk); start_p = 1'b0;
      chk("abort_rdid_read", 32'(read_p), 32'd1);
      chk("abort_rdid_addr", 32'(addr_p), 32'd0);
      // Start coinciding with counter reaching zero gives one check
      while (cyc < r5 + 12) @(negedge clk);
      start_p = 1'b1;
      q_p.push_back(mk(r5 + 16, 1'b1, 32'h0, GOOD_TS, 1'b0, 8'd0));
      @(negedge clk); start_p = 1'b0;
      chk("coinc_rdid_read", 32'(read_p), 32'd1);
      chk("coinc_rdid_addr", 32'(addr_p), 32'd0);
      @(negedge clk);
      chk("coinc_single_addr", 32'(addr_p), 32'd1);
      while (cyc < r5 + 17) @(negedge clk);
      rst_p_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("p_queue_drained", 32'(q_p.size()), 32'd0);
      chk("a_queue_final", 32'(q_a.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
